// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - 4x quadrature decoder with glitch filter, error counting and optional velocity (QUAD_VELOCITY_EN)
module quadrature_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int VEL_WINDOW = 50000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               zero_pos,
  input  logic               clear_err,
  output logic signed [23:0] position,
  output logic               err_flag,
  output logic [7:0]         err_count,
  output logic signed [23:0] velocity,
  output logic               velocity_valid
);

  localparam logic [3:0] FL    = 4'(FILTER_LEN);
  localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);

  // Bit 1 carries channel A, bit 0 carries channel B throughout.
  logic [1:0]      sync1, sync2;
  logic [1:0]      last;
  logic [1:0][3:0] cnt;
  logic [1:0]      filt;
  logic [1:0]      fvalid;
  logic [1:0]      prev;
  logic            init;
  logic [1:0]      diff;
  logic            step_fwd, step_rev, illegal;

  // Gray-coded phase to a 0..3 index along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_to_bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Two-flop synchronisers for the asynchronous encoder lines.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

  // Per-channel stability filter: any change restarts the run, a long enough run is accepted.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last   <= 2'b00;
      cnt    <= '0;
      filt   <= 2'b00;
      fvalid <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        last[i] <= sync2[i];
        if (sync2[i] != last[i]) begin
          cnt[i] <= 4'd0;
        end else begin
          if (cnt[i] != FL) cnt[i] <= cnt[i] + 4'd1;
          if (cnt[i] == FL_M1) begin
            filt[i]   <= sync2[i];
            fvalid[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Classify the move from prev to the current filtered pair; nothing decodes until prev is loaded.
  always_comb begin
    diff     = gray_to_bin(filt) - gray_to_bin(prev);
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = 1'b0;
    if (!init) begin
      case (diff)
        2'd1:    step_fwd = 1'b1;
        2'd3:    step_rev = 1'b1;
        2'd2:    illegal  = 1'b1;
        default: ;
      endcase
    end
  end

  // prev tracks the filtered pair; the first pair after reset only seeds it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prev <= 2'b00;
      init <= 1'b1;
    end else if (fvalid == 2'b11) begin
      prev <= filt;
      init <= 1'b0;
    end
  end

  // Wrapping position counter; zero_pos overrides a coincident step.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      position <= 24'sd0;
    end else if (zero_pos) begin
      position <= 24'sd0;
    end else if (step_fwd) begin
      position <= position + 24'sd1;
    end else if (step_rev) begin
      position <= position - 24'sd1;
    end
  end

  // Sticky error flag and saturating counter; a coincident illegal move survives the clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (illegal) begin
      err_flag <= 1'b1;
      if (clear_err)               err_count <= 8'd1;
      else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (clear_err) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end
  end

`ifdef QUAD_VELOCITY_EN
  localparam logic [23:0]        WIN_LAST = 24'(VEL_WINDOW - 1);
  localparam logic signed [24:0] ACC_MAX  = 25'sd8388607;

  logic [23:0]        win_cnt;
  logic signed [23:0] acc;
  logic signed [24:0] sum_raw;
  logic signed [23:0] sum_sat;

  // Accumulator plus this cycle's step, clamped to the symmetric signed range.
  always_comb begin
    sum_raw = {acc[23], acc};
    if (step_fwd)      sum_raw = sum_raw + 25'sd1;
    else if (step_rev) sum_raw = sum_raw - 25'sd1;
    if (sum_raw > ACC_MAX)       sum_sat = 24'sh7FFFFF;
    else if (sum_raw < -ACC_MAX) sum_sat = 24'sh800001;
    else                         sum_sat = sum_raw[23:0];
  end

  // Window counter; the last window cycle publishes the sum and restarts the accumulator.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      win_cnt        <= 24'd0;
      acc            <= 24'sd0;
      velocity       <= 24'sd0;
      velocity_valid <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt        <= 24'd0;
      acc            <= 24'sd0;
      velocity       <= sum_sat;
      velocity_valid <= 1'b1;
    end else begin
      win_cnt        <= win_cnt + 24'd1;
      acc            <= sum_sat;
      velocity_valid <= 1'b0;
    end
  end
`else
  // Velocity disabled: outputs tied off; the window parameter only keeps the interface identical.
  assign velocity       = 24'sd0;
  assign velocity_valid = (VEL_WINDOW < 0);
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - self-checking bench for quadrature_decoder
module tb_quadrature_decoder;

  localparam int L   = 4;
  localparam int WIN = 1000;
  localparam int LAT = L + 4;

  logic        CLK = 1'b0;
  logic        reset, enc_a, enc_b, zero_pos, clear_err;
  logic [23:0] position, velocity;
  logic        err_flag, velocity_valid;
  logic [7:0]  err_count;

  quadrature_decoder #(.FILTER_LEN(L), .VEL_WINDOW(WIN)) dut (
    .CLK(CLK), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .zero_pos(zero_pos), .clear_err(clear_err),
    .position(position), .err_flag(err_flag), .err_count(err_count),
    .velocity(velocity), .velocity_valid(velocity_valid)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: expected outputs plus per-cycle scheduled events (ring indexed by cycle).
  logic [23:0] mpos;
  bit          mflag;
  int          mcnt;
  logic [1:0]  mab;
  int          pdelta [64];
  bit          pill   [64];
  bit          pzero  [64];
  bit          pclr   [64];
  logic [1:0]  seq    [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int seq_idx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_clear();
    mpos = 24'd0; mflag = 1'b0; mcnt = 0;
    for (int i = 0; i < 64; i++) begin
      pdelta[i] = 0; pill[i] = 1'b0; pzero[i] = 1'b0; pclr[i] = 1'b0;
    end
  endtask

  // Apply whatever the model scheduled for the edge just taken.
  always @(posedge CLK) begin
    int s;
    cyc = cyc + 1;
    s = cyc % 64;
    if (!reset) begin
      if (pzero[s]) mpos = 24'd0;
      else          mpos = mpos + 24'(pdelta[s]);
      if (pill[s]) begin
        mflag = 1'b1;
        mcnt  = pclr[s] ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
      end else if (pclr[s]) begin
        mflag = 1'b0;
        mcnt  = 0;
      end
    end
    pdelta[s] = 0; pill[s] = 1'b0; pzero[s] = 1'b0; pclr[s] = 1'b0;
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("position", position, mpos);
      check("err_flag", err_flag, mflag);
      check("err_count", err_count, mcnt);
`ifndef QUAD_VELOCITY_EN
      check("velocity", velocity, 0);
      check("velocity_valid", velocity_valid, 0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive a new A/B level and schedule its decoded effect LAT cycles on.
  task automatic set_ab(input logic [1:0] ab);
    int d, s;
    d = (seq_idx(ab) - seq_idx(mab) + 4) % 4;
    s = (cyc + LAT) % 64;
    if (d == 1)      pdelta[s] = pdelta[s] + 1;
    else if (d == 3) pdelta[s] = pdelta[s] - 1;
    else if (d == 2) pill[s]   = 1'b1;
    mab = ab; enc_a = ab[1]; enc_b = ab[0];
  endtask

  task automatic step_fwd(input int n);
    for (int i = 0; i < n; i++) begin set_ab(seq[(seq_idx(mab) + 1) % 4]); tick(20); end
  endtask

  task automatic step_rev(input int n);
    for (int i = 0; i < n; i++) begin set_ab(seq[(seq_idx(mab) + 3) % 4]); tick(20); end
  endtask

  task automatic pulse_zero();
    zero_pos = 1'b1; pzero[(cyc + 1) % 64] = 1'b1; tick(1); zero_pos = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1; pclr[(cyc + 1) % 64] = 1'b1; tick(1); clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; zero_pos = 1'b0; clear_err = 1'b0;
    mab = 2'b00;
    model_clear();
    tick(3);
    chk_en = 1'b1;
    check("reset_position", position, 0);
    check("reset_err_count", err_count, 0);
    reset = 1'b0;
    tick(20);

    // Forward: 40 edges, then reverse back to zero and five further reverse edges.
    step_fwd(40);
    check("fwd40_position", position, 40);
    check("fwd40_err_flag", err_flag, 0);
    step_rev(40);
    check("rev40_position", position, 0);
    step_rev(5);
    check("rev45_position", position, 24'hFFFFFB);

    // A=1, short pulses on B must be rejected by the filter.
    for (int g = 0; g < 4; g++) begin
      enc_b = 1'b1; tick(3); enc_b = 1'b0; tick(20);
    end
    check("glitch_position", position, 24'hFFFFFB);
    check("glitch_err_flag", err_flag, 0);

    // Illegal jumps, then an illegal jump coincident with clear_err.
    step_fwd(1);
    set_ab(2'b11); tick(20);
    set_ab(2'b00); tick(20);
    check("ill2_err_count", err_count, 2);
    check("ill2_err_flag", err_flag, 1);
    set_ab(2'b11); tick(LAT - 1); pulse_clear(); tick(20);
    check("ill_clr_err_flag", err_flag, 1);
    check("ill_clr_err_count", err_count, 1);
    check("ill_position", position, 24'hFFFFFC);
    pulse_clear(); tick(3);
    check("clr_err_count", err_count, 0);

    // Wrap at the top, zero coincident with a step, wrap at the bottom.
    force dut.position = 24'h7FFFFF; mpos = 24'h7FFFFF; tick(1);
    release dut.position; tick(2);
    set_ab(2'b10); tick(LAT - 1);
    check("wrap_up_before", position, 24'h7FFFFF);
    tick(1);
    check("wrap_up_after", position, 24'h800000);
    tick(20);
    set_ab(2'b00); tick(LAT - 1); pulse_zero(); tick(20);
    check("zero_wins", position, 0);
    force dut.position = 24'h800000; mpos = 24'h800000; tick(1);
    release dut.position; tick(2);
    set_ab(2'b10); tick(LAT + 2);
    check("wrap_down", position, 24'h7FFFFF);
    tick(20);

`ifdef QUAD_VELOCITY_EN
    begin
      int strobes, last_c;
      strobes = 0; last_c = 0;
      for (int k = 0; k < 3500 && strobes < 4; k++) begin
        if (k % 10 == 0) set_ab(seq[(seq_idx(mab) + 1) % 4]);
        tick(1);
        if (velocity_valid) begin
          strobes++;
          if (strobes >= 2) begin
            check("velocity_value", velocity, 100);
            check("velocity_gap", cyc - last_c, WIN);
          end
          last_c = cyc;
        end
      end
      check("velocity_strobes", strobes >= 3, 1);
      tick(20);
    end
`endif

    // Reset mid-rotation with an edge still in flight; init rule applies afterwards.
    set_ab(seq[(seq_idx(mab) + 1) % 4]); tick(3);
    reset = 1'b1; model_clear(); #1;
    check("async_reset_position", position, 0);
    tick(3);
    reset = 1'b0;
    tick(25);
    check("post_reset_position", position, 0);
    check("post_reset_err_flag", err_flag, 0);
    set_ab(seq[(seq_idx(mab) + 1) % 4]); tick(LAT + 2);
    check("post_reset_step", position, 1);
    tick(5);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
